// File: rtl/exec_prepros_p.sv
// rtl/exec_prepros_p.sv - DLX execute-stage operand preprocessor with store serializer
module exec_prepros_p #(
   parameter int DATA_W    = 32,
   parameter int SHAMT_W   = 5,
   parameter int SER_LANES = 1
) (
   input  logic                 clk1,
   input  logic                 rst1,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    src1,
   input  logic [DATA_W-1:0]    src2,
   input  logic [DATA_W-1:0]    imm,
   input  logic [DATA_W-1:0]    mem_rdata,
   input  logic [6:0]           cntrl_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    aluin1,
   output logic [DATA_W-1:0]    aluin2,
   output logic [2:0]           op,
   output logic [2:0]           opsel,
   output logic [SHAMT_W-1:0]   shift_nos,
   output logic                 en_ar,
   output logic                 en_sh,
   output logic                 mem_wr_en,
   output logic [SER_LANES-1:0] mem_write_out,
   output logic                 mem_wr_last
);
   localparam int BEATS = DATA_W / SER_LANES;
   localparam int CNT_W = $clog2(BEATS + 1);

   localparam logic [2:0] OPS_SHIFT = 3'b000;
   localparam logic [2:0] OPS_ARITH = 3'b001;
   localparam logic [2:0] OPS_MWR   = 3'b100;
   localparam logic [2:0] OPS_MRD   = 3'b101;

   typedef enum logic [1:0] {IDLE, HOLD, SER} state_t;

   state_t              state_q;
   logic                out_valid_q;
   logic [DATA_W-1:0]   aluin1_q, aluin2_q, shreg_q;
   logic [2:0]          op_q, opsel_q;
   logic [SHAMT_W-1:0]  shift_nos_q;
   logic                en_ar_q, en_sh_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                accept, imm_regn;
   logic [2:0]          opsel_in;
   logic [DATA_W-1:0]   aluin2_d;
   logic [SHAMT_W-1:0]  shift_nos_d;
   logic                en_ar_d, en_sh_d;

   assign in_ready = (state_q == IDLE) || (state_q == HOLD && out_ready);
   assign accept   = in_valid && in_ready;
   assign imm_regn = cntrl_in[3];
   assign opsel_in = cntrl_in[2:0];

   always_comb begin
      aluin2_d    = '0;
      shift_nos_d = '0;
      en_ar_d     = 1'b0;
      en_sh_d     = 1'b0;
      case (opsel_in)
         OPS_ARITH: begin
            aluin2_d = imm_regn ? imm : src2;
            en_ar_d  = 1'b1;
         end
         OPS_MRD: begin
            aluin2_d = imm_regn ? mem_rdata : '0;
            en_ar_d  = imm_regn;
         end
         OPS_SHIFT: begin
            // imm[2] selects a register-sourced shift amount over the immediate field
            shift_nos_d = imm[2] ? src2[SHAMT_W-1:0] : imm[6+SHAMT_W-1:6];
            en_sh_d     = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (rst1) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         aluin1_q    <= '0;
         aluin2_q    <= '0;
         op_q        <= '0;
         opsel_q     <= '0;
         shift_nos_q <= '0;
         en_ar_q     <= 1'b0;
         en_sh_q     <= 1'b0;
         shreg_q     <= '0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            IDLE, HOLD: begin
               if (accept) begin
                  aluin1_q    <= src1;
                  aluin2_q    <= aluin2_d;
                  op_q        <= cntrl_in[6:4];
                  opsel_q     <= opsel_in;
                  shift_nos_q <= shift_nos_d;
                  en_ar_q     <= en_ar_d;
                  en_sh_q     <= en_sh_d;
                  if (opsel_in == OPS_MWR && imm_regn) begin
                     state_q     <= SER;
                     out_valid_q <= 1'b0;
                     shreg_q     <= src2;
                     cnt_q       <= CNT_W'(BEATS);
                  end else begin
                     state_q     <= HOLD;
                     out_valid_q <= 1'b1;
                  end
               end else if (state_q == HOLD && out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            SER: begin
               shreg_q <= shreg_q >> SER_LANES;
               cnt_q   <= cnt_q - CNT_W'(1);
               // the completion token reuses the fields loaded at accept
               if (cnt_q == CNT_W'(1)) begin
                  state_q     <= HOLD;
                  out_valid_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid     = out_valid_q;
   assign aluin1        = aluin1_q;
   assign aluin2        = aluin2_q;
   assign op            = op_q;
   assign opsel         = opsel_q;
   assign shift_nos     = shift_nos_q;
   assign en_ar         = en_ar_q;
   assign en_sh         = en_sh_q;
   assign mem_wr_en     = (state_q == SER);
   assign mem_write_out = (state_q == SER) ? shreg_q[SER_LANES-1:0] : '0;
   assign mem_wr_last   = (state_q == SER) && (cnt_q == CNT_W'(1));
endmodule

// File: tb/tb_exec_prepros_p.sv
// tb/tb_exec_prepros_p.sv - scoreboard bench for exec_prepros_p
module tb_exec_prepros_p;
   logic        clk1 = 1'b0;
   logic        rst1, in_valid, in_valid4, out_ready;
   logic [31:0] src1, src2, imm, mem_rdata;
   logic [6:0]  cntrl_in;

   logic        in_ready, out_valid, en_ar, en_sh, mem_wr_en, mem_wr_last;
   logic [31:0] aluin1, aluin2;
   logic [2:0]  op, opsel;
   logic [4:0]  shift_nos;
   logic [0:0]  mem_write_out;

   logic        in_ready4, out_valid4, en_ar4, en_sh4, mem_wr_en4, mem_wr_last4;
   logic [31:0] aluin1_4, aluin2_4;
   logic [2:0]  op4, opsel4;
   logic [4:0]  shift_nos4;
   logic [3:0]  mem_write_out4;

   typedef struct packed {
      logic [31:0] a1;
      logic [31:0] a2;
      logic [2:0]  op;
      logic [2:0]  opsel;
      logic [4:0]  sh;
      logic        ar;
      logic        sh_en;
   } exp_t;

   exp_t exp_q[$];
   logic beat_q[$];
   exp_t mon_e;
   logic mon_b;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk1 = ~clk1;

   exec_prepros_p #(.DATA_W(32), .SHAMT_W(5), .SER_LANES(1)) dut (
      .clk1(clk1), .rst1(rst1), .in_valid(in_valid), .in_ready(in_ready),
      .src1(src1), .src2(src2), .imm(imm), .mem_rdata(mem_rdata), .cntrl_in(cntrl_in),
      .out_valid(out_valid), .out_ready(out_ready), .aluin1(aluin1), .aluin2(aluin2),
      .op(op), .opsel(opsel), .shift_nos(shift_nos), .en_ar(en_ar), .en_sh(en_sh),
      .mem_wr_en(mem_wr_en), .mem_write_out(mem_write_out), .mem_wr_last(mem_wr_last)
   );

   exec_prepros_p #(.DATA_W(32), .SHAMT_W(5), .SER_LANES(4)) dut4 (
      .clk1(clk1), .rst1(rst1), .in_valid(in_valid4), .in_ready(in_ready4),
      .src1(src1), .src2(src2), .imm(imm), .mem_rdata(mem_rdata), .cntrl_in(cntrl_in),
      .out_valid(out_valid4), .out_ready(out_ready), .aluin1(aluin1_4), .aluin2(aluin2_4),
      .op(op4), .opsel(opsel4), .shift_nos(shift_nos4), .en_ar(en_ar4), .en_sh(en_sh4),
      .mem_wr_en(mem_wr_en4), .mem_write_out(mem_write_out4), .mem_wr_last(mem_wr_last4)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [6:0] c, input logic [31:0] s1, s2, im, md);
      exp_t e;
      e       = '0;
      e.a1    = s1;
      e.op    = c[6:4];
      e.opsel = c[2:0];
      case (c[2:0])
         3'b001: begin e.a2 = c[3] ? im : s2; e.ar = 1'b1; end
         3'b101: begin e.a2 = c[3] ? md : 32'h0; e.ar = c[3]; end
         3'b000: begin e.sh = im[2] ? s2[4:0] : im[10:6]; e.sh_en = 1'b1; end
         default: ;
      endcase
      return e;
   endfunction

   always @(negedge clk1) begin
      if (!rst1) begin
         if (out_valid) begin
            if (exp_q.size() == 0) chk("res_unexp", 1, 0);
            else begin
               mon_e = exp_q[0];
               chk("aluin1", aluin1, mon_e.a1);
               chk("aluin2", aluin2, mon_e.a2);
               chk("op", op, mon_e.op);
               chk("opsel", opsel, mon_e.opsel);
               chk("shift_nos", shift_nos, mon_e.sh);
               chk("en_ar", en_ar, mon_e.ar);
               chk("en_sh", en_sh, mon_e.sh_en);
               chk("hold_in_ready", in_ready, out_ready);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         if (mem_wr_en) begin
            chk("ser_in_ready", in_ready, 0);
            if (beat_q.size() == 0) chk("beat_unexp", 1, 0);
            else begin
               mon_b = beat_q.pop_front();
               chk("beat", mem_write_out, mon_b);
               chk("beat_last", mem_wr_last, beat_q.size() == 0);
            end
         end else begin
            chk("wr_idle", {mem_wr_last, mem_write_out}, 0);
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(cntrl_in, src1, src2, imm, mem_rdata));
            if (cntrl_in[3:0] == 4'b1100)
               for (int i = 0; i < 32; i++) beat_q.push_back(src2[i]);
         end
      end
   end

   task automatic send(input logic [6:0] c, input logic [31:0] s1, s2, im, md);
      int n;
      cntrl_in = c; src1 = s1; src2 = s2; imm = im; mem_rdata = md;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk1);
      while (!in_ready && n < 200) begin
         @(negedge clk1);
         n++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      @(posedge clk1);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mem_wr_en || out_valid) && n < 200) begin
         @(posedge clk1);
         #1;
         n++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_fields"}, {aluin1, aluin2, op, opsel, shift_nos, en_ar, en_sh}, 0);
      chk({tag, "_wr"}, {mem_wr_en, mem_write_out, mem_wr_last}, 0);
   endtask

   initial begin
      rst1 = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
      src1 = '0; src2 = '0; imm = '0; mem_rdata = '0; cntrl_in = '0;
      repeat (2) @(posedge clk1);
      #1 rst1 = 1'b0;
      check_zero("reset");

      send(7'b010_1_001, 32'h11, 32'h5, 32'hFFFF_FFF0, 32'h0);
      send(7'b011_0_001, 32'h1234, 32'h5678, 32'hFFFF_FFF0, 32'h0);
      send(7'b000_0_000, 32'h1, 32'h2, 32'h0000_0340, 32'h0);
      send(7'b001_0_000, 32'h1, 32'h27, 32'h0000_0004, 32'h0);
      send(7'b100_1_101, 32'h5, 32'h6, 32'h7, 32'hCAFE_F00D);
      send(7'b100_0_101, 32'h8, 32'h9, 32'hA, 32'hBEEF);
      send(7'b000_0_100, 32'h100, 32'hDEAD, 32'h0, 32'h0);
      send(7'b110_1_011, 32'h33, 32'h44, 32'h55, 32'h66);
      send(7'b000_1_100, 32'h200, 32'h8000_0005, 32'h0, 32'h0);
      for (int k = 0; k < 8; k++)
         send(7'($urandom_range(0, 127)), $urandom, $urandom, $urandom, $urandom);
      drain();

      out_ready = 1'b0;
      send(7'b101_1_001, 32'hA0, 32'hA1, 32'hA2, 32'h0);
      cntrl_in = 7'b111_0_001; src1 = 32'hB0; src2 = 32'hB1; imm = 32'hB2; in_valid = 1'b1;
      repeat (3) @(posedge clk1);
      #1 out_ready = 1'b1;
      send(7'b111_0_001, 32'hB0, 32'hB1, 32'hB2, 32'h0);
      chk("bp_no_bubble", out_valid, 1);
      drain();

      cntrl_in = 7'b010_1_100; src1 = 32'h4000; src2 = 32'h8765_4321; in_valid4 = 1'b1;
      @(posedge clk1);
      #1 in_valid4 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("l4_wr_en", mem_wr_en4, 1);
         chk("l4_beat", mem_write_out4, k + 1);
         chk("l4_last", mem_wr_last4, k == 7);
         chk("l4_in_ready", in_ready4, 0);
         @(posedge clk1);
         #1;
      end
      chk("l4_token_valid", out_valid4, 1);
      chk("l4_token_a1", aluin1_4, 32'h4000);
      chk("l4_token_en", {en_ar4, en_sh4, mem_wr_en4}, 0);
      @(posedge clk1);
      #1;

      send(7'b000_1_100, 32'h300, 32'hA5A5_A5A5, 32'h0, 32'h0);
      repeat (4) @(posedge clk1);
      #1 rst1 = 1'b1;
      @(posedge clk1);
      #1 rst1 = 1'b0;
      exp_q.delete();
      beat_q.delete();
      check_zero("ser_reset");
      repeat (5) begin
         @(negedge clk1);
         chk("ser_reset_no_beat", mem_wr_en, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/exec_prepros_p.md
Name: exec_prepros_p

Overview:
- Parametrised execute-stage operand preprocessor for the DLX pipeline.
- Accepts one decoded instruction per handshake and registers the ALU/shifter operands, enables and opcode fields into an output stage with valid/ready flow control.
- Contains a store serializer that streams the store word to memory SER_LANES bits per cycle, LSB first.
- Sits between register-read/decode and the ALU/shifter units.

Parameters:
- DATA_W, 32, operand/immediate/store data width; must be >= 8.
- SHAMT_W, 5, shift-amount width; must equal log2(DATA_W); 6+SHAMT_W <= DATA_W.
- SER_LANES, 1, store bits emitted per cycle; must divide DATA_W.

Ports:
- clk1  in  1  clock, all state on rising edge
- rst1  in  1  synchronous active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  block accepts instruction this cycle
- src1  in  DATA_W  register operand 1
- src2  in  DATA_W  register operand 2 / store data
- imm  in  DATA_W  sign-extended immediate / shift-field carrier
- mem_rdata  in  DATA_W  load data
- cntrl_in  in  7  [6:4]=op, [3]=imm_regn, [2:0]=opsel
- out_valid  out  1  output stage holds a result
- out_ready  in  1  downstream accepts result
- aluin1, aluin2  out  DATA_W  ALU operands
- op, opsel  out  3  registered opcode fields
- shift_nos  out  SHAMT_W  shift amount
- en_ar, en_sh  out  1  arithmetic / shift unit enables
- mem_wr_en  out  1  store beat valid
- mem_write_out  out  SER_LANES  store data beat
- mem_wr_last  out  1  final store beat

Behaviour:
- opsel codes: SHIFT_REG=000, ARITH_LOGIC=001, MEM_WRITE=100, MEM_READ=101; any other code is "other".
- Reset (rst1=1 at edge): state=IDLE; every output 0 (in_ready reads 1 the cycle after reset); serializer shift register and beat counter cleared. Reset aborts a serialization in progress immediately; no further beats are emitted.
- FSM states: IDLE, HOLD, SER.
- in_ready = (IDLE) or (HOLD and out_ready); 0 in SER.
- Accept = in_valid & in_ready. On accept, all output fields are loaded at the same edge from the current inputs (latency 1, no stale-field use):
  - op, opsel and the internal imm_regn come from cntrl_in.
  - aluin1 = src1.
  - aluin2 = ARITH_LOGIC: imm if imm_regn, else src2. MEM_READ: mem_rdata if imm_regn, else 0. Otherwise 0.
  - shift_nos = SHIFT_REG: src2[SHAMT_W-1:0] if imm[2], else imm[6+SHAMT_W-1:6]. Otherwise 0.
  - en_ar = 1 for ARITH_LOGIC, or for MEM_READ with imm_regn; else 0.
  - en_sh = 1 only for SHIFT_REG.
- Transitions:
  - Accept of MEM_WRITE with imm_regn=1 -> SER: shift register <= src2, beat count <= DATA_W/SER_LANES, out_valid=0.
  - Any other accept -> HOLD, out_valid=1.
  - HOLD with out_ready and no accept -> IDLE, out_valid=0.
  - HOLD with out_ready and accept -> back-to-back load, no bubble.
  - HOLD with out_ready=0: all outputs stable.
- SER, each cycle:
  - mem_wr_en=1; mem_write_out = shreg[SER_LANES-1:0].
  - Shift register shifts right by SER_LANES; count decrements.
  - mem_wr_last=1 on the beat where count==1.
  - The next edge after the last beat -> HOLD with out_valid=1 and en_ar=en_sh=0. This is the store completion token; aluin1 holds src1, the address base.
- mem_wr_en, mem_write_out and mem_wr_last are 0 outside SER.
- MEM_WRITE with imm_regn=0 produces no store beats and goes straight to HOLD with en_ar=en_sh=0.
- in_valid asserted during SER is ignored (not accepted). The source must hold it; the block drops nothing.
- Other opsel: fields pass through, aluin2=0, shift_nos=0, enables 0, normal HOLD.

Test Plan:
- Reset during SER after 5 beats -> next cycle all outputs 0, IDLE, in_ready=1, no further mem_wr_en.
- ARITH_LOGIC imm: cntrl_in=7'b010_1_001, src1=0x11, imm=0xFFFF_FFF0, out_ready=1 -> next cycle out_valid=1, aluin1=0x11, aluin2=0xFFFF_FFF0, op=010, en_ar=1, en_sh=0.
- SHIFT_REG both sources:
  - imm[2]=0, imm[10:6]=5'd13 -> shift_nos=13, en_sh=1, en_ar=0.
  - imm[2]=1, src2=0x27 -> shift_nos=7.
- Store, SER_LANES=1: cntrl_in=7'b000_1_100, src2=0x8000_0005 -> 32 cycles mem_wr_en=1, beat values 1,0,1,0…, last beat 1 with mem_wr_last=1. in_ready=0 throughout; then out_valid=1.
- Store, SER_LANES=4, DATA_W=32: src2=0x8765_4321 -> 8 beats 1,2,3,4,5,6,7,8; mem_wr_last on the 8th beat.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> outputs stable, in_ready=0. Raising out_ready accepts the next instruction at that edge; no bubble, no duplicate result.
